uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive buffer between the UART receiver and the Z80 I/O register decode. It takes bytes from the receiver's `rx_data`/`rx_data_ready`/`rx_clear` handshake and stores them in a small FIFO. It presents the head byte, a data-available flag, an interrupt request and an RTS flow-control output to the CPU side. This lets the Z80 tolerate back-to-back characters at 115200 bps without losing data to interrupt latency.

## Interface
Parameters:
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 bytes (16).
- `HIGH_WATER`, 12: occupancy at or above which `rts_n` deasserts.
- `LOW_WATER`, 4: occupancy at or below which `rts_n` reasserts. Must be < HIGH_WATER.

Ports:
- `clk`  in  1  single clock; all registers on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  byte from receiver (`rx_data`).
- `in_ready`  in  1  receiver byte valid (`rx_data_ready`), level.
- `in_clear`  out  1  acknowledge to receiver (`rx_clear`), level.
- `rd_pop`  in  1  one-cycle pulse: CPU consumed head byte.
- `rd_data`  out  8  head byte; valid when `rd_avail`=1.
- `rd_avail`  out  1  FIFO non-empty.
- `count`  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `ovr_clear`  in  1  one-cycle pulse clearing `overrun`.
- `rts_n`  out  1  0 = host may send; 1 = hold off.
- `int_n`  out  1  active-low interrupt, equals ~`rd_avail`.

## Operation
- Storage: 2^DEPTH_LOG2 x 8 array with write pointer, read pointer and a count register.
  - Pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - full = (count == 2^DEPTH_LOG2); empty = (count == 0).
- Ingress FSM, states IDLE and ACK:
  - IDLE, `in_ready`=1, not full: write `in_data` at wr_ptr, increment wr_ptr, go to ACK.
  - IDLE, `in_ready`=1, full, `rd_pop`=1 in the same cycle: accept the byte as in the non-full case. Count is unchanged.
  - IDLE, `in_ready`=1, full, no pop: drop the byte, set `overrun`=1, go to ACK.
  - ACK: `in_clear`=1 (registered, high for the whole state). Stay while `in_ready`=1; return to IDLE on the first cycle `in_ready`=0.
  - Exactly one push or drop happens per receiver byte, regardless of how long `in_ready` stays high.
- Egress:
  - `rd_data` = array[rd_ptr], combinational from storage.
  - `rd_pop` with `rd_avail`=1 increments rd_ptr.
  - `rd_pop` when empty is ignored: no pointer or count change.
- Count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Overrun: set on a drop; cleared by `ovr_clear`. If both occur in the same cycle, set wins.
- RTS hysteresis (registered):
  - `rts_n` goes to 1 when the next count is >= HIGH_WATER.
  - `rts_n` goes to 0 when the next count is <= LOW_WATER.
  - Otherwise `rts_n` holds.
- `rd_avail` = (count != 0); `int_n` = ~`rd_avail`. Both derive from the registered count.

## Timing
- Reset values (asynchronous): state=IDLE, pointers=0, count=0, `in_clear`=0, `overrun`=0, `rts_n`=0. Therefore `rd_avail`=0 and `int_n`=1. Array contents are undefined.
- Push latency: `in_ready` sampled high at edge N gives the following, all after edge N:
  - `count` increments, `rd_avail`=1, `int_n`=0, `rd_data` = that byte (if the FIFO was empty).
  - `in_clear`=1.
- `in_clear` falls on the first edge at which `in_ready` is sampled 0.
- A new byte is accepted no earlier than the cycle after returning to IDLE.
- Pop: `rd_pop` at edge N means `rd_data` shows the next byte after edge N, and `count` decrements at edge N.
- Wrap-around: pointer 15 -> 0 with no bubble.
- Reset asserted mid-ACK: `in_clear` drops immediately and the FIFO empties. If the receiver still holds `in_ready`=1 after release, that byte is captured once as a new byte.

## Test plan
- Reset, then one byte 0x41 via `in_ready`. Required: `rd_avail`=1, `int_n`=0, `rd_data`=0x41, `count`=1, one-cycle `in_clear` handshake. Then `rd_pop`: `count`=0, `int_n`=1.
- Hold `in_ready` high for 10 cycles with 0x55. Required: `count`=1 only, `in_clear` held high until `in_ready` falls.
- Push 0x00..0x0F (16 bytes), then 0xAA. Required: `count`=16, 0xAA dropped, `overrun`=1. Popping 16 times returns 0x00..0x0F in order. `ovr_clear` then clears `overrun`.
- Push 12 bytes. Required: `rts_n`=1 after the 12th push. Pop down to 5: still 1. Pop to 4: `rts_n`=0.
- With the FIFO full, present 0xBB with a simultaneous `rd_pop`. Required: 0xBB accepted, `count` stays 16, `overrun` stays 0, and 0xBB is the last byte read.
- Push 20 bytes with a pop after each. Required: pointers wrap past 15, data order preserved, `rd_pop` on empty has no effect (`count` stays 0).

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver handshake and the Z80 register decode.
// Buffers bytes, flags overrun, and drives RTS flow control and the CPU interrupt.
//
// state | meaning
// IDLE  | waiting for the receiver to present a byte
// ACK   | byte taken or dropped; in_clear held until in_ready falls
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int HIGH_WATER = 12,
    parameter int LOW_WATER  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            in_data,
    input  logic                  in_ready,
    output logic                  in_clear,
    input  logic                  rd_pop,
    output logic [7:0]            rd_data,
    output logic                  rd_avail,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    input  logic                  ovr_clear,
    output logic                  rts_n,
    output logic                  int_n
);

    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] HW_CNT   = CW'(HIGH_WATER);
    localparam logic [CW-1:0] LW_CNT   = CW'(LOW_WATER);

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  full;
    logic                  accept;
    logic                  push;
    logic                  drop;
    logic                  pop;
    logic [CW-1:0]         count_next;

    assign full     = (count == FULL_CNT);
    assign rd_avail = (count != '0);
    assign int_n    = ~rd_avail;
    assign rd_data  = mem[rd_ptr];

    // A full FIFO still takes the byte when the CPU frees a slot in the same cycle.
    assign accept = (state == IDLE) && in_ready;
    assign pop    = rd_pop && rd_avail;
    assign push   = accept && (!full || rd_pop);
    assign drop   = accept && full && !rd_pop;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            in_clear <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overrun  <= 1'b0;
            rts_n    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_ready) begin
                        state    <= ACK;
                        in_clear <= 1'b1;
                    end
                end
                ACK: begin
                    if (!in_ready) begin
                        state    <= IDLE;
                        in_clear <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_clear <= 1'b0;
                end
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;

            if (drop) begin
                overrun <= 1'b1;
            end else if (ovr_clear) begin
                overrun <= 1'b0;
            end

            if (count_next >= HW_CNT) begin
                rts_n <= 1'b1;
            end else if (count_next <= LW_CNT) begin
                rts_n <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_ready;
    logic       in_clear;
    logic       rd_pop;
    logic [7:0] rd_data;
    logic       rd_avail;
    logic [4:0] count;
    logic       overrun;
    logic       ovr_clear;
    logic       rts_n;
    logic       int_n;

    int vectors;
    int miscompares;

    uart_rx_fifo #(.DEPTH_LOG2(4), .HIGH_WATER(12), .LOW_WATER(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_ready(in_ready),
        .in_clear(in_clear), .rd_pop(rd_pop), .rd_data(rd_data), .rd_avail(rd_avail),
        .count(count), .overrun(overrun), .ovr_clear(ovr_clear), .rts_n(rts_n),
        .int_n(int_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a byte queue, a "receiver byte already handled" flag,
    // the sticky overrun bit and the RTS hysteresis flag.
    logic [7:0] q[$];
    logic       m_busy;
    logic       m_ovr;
    logic       m_rts;
    int         m_n;
    logic       m_popped;
    logic       m_acc;
    logic       m_take;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_busy = 1'b0;
            m_ovr  = 1'b0;
            m_rts  = 1'b0;
        end else begin
            m_n      = q.size();
            m_popped = rd_pop && (m_n > 0);
            m_acc    = !m_busy && in_ready;
            m_take   = m_acc && ((m_n < DEPTH) || m_popped);
            if (m_popped) void'(q.pop_front());
            if (m_take) q.push_back(in_data);
            if (m_acc && !m_take) m_ovr = 1'b1;
            else if (ovr_clear) m_ovr = 1'b0;
            if (m_acc) m_busy = 1'b1;
            else if (!in_ready) m_busy = 1'b0;
            if (q.size() >= 12) m_rts = 1'b1;
            else if (q.size() <= 4) m_rts = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic model_on;
    initial model_on = 1'b0;

    always @(negedge clk) begin
        if (model_on) begin
            chk("count", int'(count), q.size());
            chk("rd_avail", int'(rd_avail), int'(q.size() != 0));
            chk("int_n", int'(int_n), int'(q.size() == 0));
            chk("in_clear", int'(in_clear), int'(m_busy));
            chk("overrun", int'(overrun), int'(m_ovr));
            chk("rts_n", int'(rts_n), int'(m_rts));
            if (q.size() != 0) chk("rd_data", int'(rd_data), int'(q[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int hold);
        in_data  = b;
        in_ready = 1'b1;
        repeat (hold) step();
        in_ready = 1'b0;
        step();
    endtask

    task automatic pop();
        rd_pop = 1'b1;
        step();
        rd_pop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n   = 1'b0;
        in_data   = 8'h00;
        in_ready  = 1'b0;
        rd_pop    = 1'b0;
        ovr_clear = 1'b0;
        repeat (3) step();
        model_on = 1'b1;
        chk("reset_int_n", int'(int_n), 1);
        chk("reset_rts_n", int'(rts_n), 0);
        reset_n = 1'b1;
        step();

        // single byte handshake
        in_data  = 8'h41;
        in_ready = 1'b1;
        step();
        chk("t1_in_clear_hi", int'(in_clear), 1);
        chk("t1_rd_data", int'(rd_data), 'h41);
        chk("t1_count", int'(count), 1);
        chk("t1_int_n", int'(int_n), 0);
        in_ready = 1'b0;
        step();
        chk("t1_in_clear_lo", int'(in_clear), 0);
        pop();
        chk("t1_pop_count", int'(count), 0);
        chk("t1_pop_int_n", int'(int_n), 1);

        // long in_ready: one byte only
        in_data  = 8'h55;
        in_ready = 1'b1;
        repeat (10) step();
        chk("t2_in_clear_held", int'(in_clear), 1);
        chk("t2_count", int'(count), 1);
        in_ready = 1'b0;
        step();
        chk("t2_in_clear_lo", int'(in_clear), 0);
        pop();

        // fill, overrun, drain in order, clear overrun
        for (int i = 0; i < 16; i++) send(8'(i), 1);
        send(8'hAA, 1);
        chk("t3_count_full", int'(count), 16);
        chk("t3_overrun", int'(overrun), 1);
        for (int i = 0; i < 16; i++) begin
            chk("t3_order", int'(rd_data), i);
            pop();
        end
        chk("t3_empty", int'(count), 0);
        chk("t3_ovr_sticky", int'(overrun), 1);
        ovr_clear = 1'b1;
        step();
        ovr_clear = 1'b0;
        chk("t3_ovr_cleared", int'(overrun), 0);

        // RTS hysteresis
        for (int i = 0; i < 11; i++) send(8'h60 + 8'(i), 1);
        chk("t4_rts_11", int'(rts_n), 0);
        in_data  = 8'h6B;
        in_ready = 1'b1;
        step();
        chk("t4_rts_12", int'(rts_n), 1);
        in_ready = 1'b0;
        step();
        repeat (7) pop();
        chk("t4_count_5", int'(count), 5);
        chk("t4_rts_5", int'(rts_n), 1);
        pop();
        chk("t4_rts_4", int'(rts_n), 0);
        repeat (4) pop();

        // full FIFO with simultaneous push and pop
        for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 1);
        in_data  = 8'hBB;
        in_ready = 1'b1;
        rd_pop   = 1'b1;
        step();
        rd_pop   = 1'b0;
        chk("t5_count", int'(count), 16);
        chk("t5_overrun", int'(overrun), 0);
        in_ready = 1'b0;
        step();
        for (int i = 1; i < 16; i++) begin
            chk("t5_order", int'(rd_data), 'h10 + i);
            pop();
        end
        chk("t5_last_bb", int'(rd_data), 'hBB);
        pop();
        chk("t5_empty", int'(count), 0);

        // wrap-around with pop after each push, then pop on empty
        for (int i = 0; i < 20; i++) begin
            send(8'hC0 + 8'(i), 1);
            chk("t6_data", int'(rd_data), 'hC0 + i);
            pop();
        end
        pop();
        chk("t6_pop_empty", int'(count), 0);
        chk("t6_pop_empty_int", int'(int_n), 1);

        // reset in the middle of a handshake
        send(8'h33, 1);
        in_data  = 8'h77;
        in_ready = 1'b1;
        step();
        chk("t7_ack", int'(in_clear), 1);
        reset_n = 1'b0;
        #1;
        chk("t7_clear_drop", int'(in_clear), 0);
        chk("t7_flush", int'(count), 0);
        step();
        reset_n = 1'b1;
        step();
        chk("t7_recapture_cnt", int'(count), 1);
        chk("t7_recapture_data", int'(rd_data), 'h77);
        repeat (3) step();
        chk("t7_once", int'(count), 1);
        in_ready = 1'b0;
        step();
        pop();
        step();

        model_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
